// File: rtl/llvga_rx_pkg.sv
// llvga_rx_pkg: shared VGA link types (mode record, receiver states).
// Used by the low-level VGA transmitter and llvga_rx.
package llvga_rx_pkg;

  localparam int MW = 12;

  typedef logic [MW-1:0] mword_t;

  typedef enum logic [1:0] {
    SEARCH     = 2'b00,
    HSYNC_WAIT = 2'b01,
    HLOCK      = 2'b10,
    LOCKED     = 2'b11
  } rx_state_t;

  typedef struct packed {
    mword_t width;
    mword_t porch;
    mword_t synch;
    mword_t raw;
  } mode_t;

  function automatic mword_t wrap_inc(mword_t p, mword_t raw);
    return (p == raw - 1'b1) ? '0 : p + 1'b1;
  endfunction

  function automatic mword_t sat_inc(mword_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/llvga_rx_axis.sv
// llvga_rx_axis: one timing axis (position, sync edges, pulse/period check).
// LLVGA_RX_MEASURE_EN adds measured period/pulse outputs.
module llvga_rx_axis
  import llvga_rx_pkg::*;
(
  input  logic          i_pixclk,
  input  logic          i_reset_n,
  input  logic [MW-1:0] i_porch,
  input  logic [MW-1:0] i_synch,
  input  logic [MW-1:0] i_raw,
  input  logic          i_adv,
  input  logic          i_smp,
  input  logic          i_sync,
  output logic [MW-1:0] o_pos,
  output logic          o_rise,
  output logic          o_wrap,
  output logic          o_viol
`ifdef LLVGA_RX_MEASURE_EN
  ,
  output logic [MW-1:0] o_meas_raw,
  output logic [MW-1:0] o_meas_pulse
`endif
);

  logic   sync_d;
  logic   seen;
  logic   rise;
  logic   fall;
  logic   wrap;
  mword_t pos;
  mword_t cur;
  mword_t per;
  mword_t len;

  assign rise = i_smp & i_sync & ~sync_d;
  assign fall = i_smp & ~i_sync & sync_d;
  assign wrap = i_adv & ~rise & (pos == i_raw - 1'b1);

  always_comb begin
    cur = pos;
    if (rise)
      cur = i_porch;
    else if (i_adv)
      cur = wrap_inc(pos, i_raw);
  end

  // a wrap with no rising edge since the last wrap is a lost sync
  assign o_viol = (rise & (per != i_raw))
                | (fall & (len != i_synch - i_porch))
                | (wrap & ~seen);
  assign o_pos  = cur;
  assign o_rise = rise;
  assign o_wrap = wrap;

  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      sync_d <= 1'b0;
      seen   <= 1'b0;
      pos    <= '0;
      per    <= '0;
      len    <= '0;
    end else begin
      pos <= cur;
      if (i_smp) begin
        sync_d <= i_sync;
        per    <= rise ? mword_t'(1) : sat_inc(per);
        if (rise)
          len <= mword_t'(1);
        else if (i_sync)
          len <= sat_inc(len);
      end
      if (rise)
        seen <= 1'b1;
      else if (wrap)
        seen <= 1'b0;
    end
  end

`ifdef LLVGA_RX_MEASURE_EN
  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      o_meas_raw   <= '0;
      o_meas_pulse <= '0;
    end else if (rise) begin
      o_meas_raw   <= per;
      o_meas_pulse <= len;
    end
  end
`endif

endmodule

// File: rtl/llvga_rx.sv
// llvga_rx: VGA link receiver, sync-locked framed pixel stream.
// LLVGA_RX_MEASURE_EN adds o_meas_* timing measurement outputs.
module llvga_rx
  import llvga_rx_pkg::*;
#(
  parameter int BITS_PER_COLOR = 4,
  parameter int LOCK_FRAMES    = 2
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset_n,
  input  logic [11:0]                 i_hm_width,
  input  logic [11:0]                 i_hm_porch,
  input  logic [11:0]                 i_hm_synch,
  input  logic [11:0]                 i_hm_raw,
  input  logic [11:0]                 i_vm_height,
  input  logic [11:0]                 i_vm_porch,
  input  logic [11:0]                 i_vm_synch,
  input  logic [11:0]                 i_vm_raw,
  input  logic                        i_hsync,
  input  logic                        i_vsync,
  input  logic [BITS_PER_COLOR-1:0]   i_red,
  input  logic [BITS_PER_COLOR-1:0]   i_grn,
  input  logic [BITS_PER_COLOR-1:0]   i_blu,
  output logic                        o_valid,
  output logic [3*BITS_PER_COLOR-1:0] o_pixel,
  output logic                        o_hlast,
  output logic                        o_vlast,
  output logic                        o_locked,
  output logic                        o_err
`ifdef LLVGA_RX_MEASURE_EN
  ,
  output logic [11:0]                 o_meas_hraw,
  output logic [11:0]                 o_meas_hsync,
  output logic [11:0]                 o_meas_vraw,
  output logic [11:0]                 o_meas_vsync
`endif
);

  localparam int PW = 3 * BITS_PER_COLOR;
  localparam logic [3:0] LF = 4'(LOCK_FRAMES);

  mode_t         hm;
  mode_t         vm;
  logic          r_hs;
  logic          r_vs;
  logic [PW-1:0] r_rgb;
  rx_state_t     state;
  logic [3:0]    cnt;

  always_ff @(posedge i_pixclk) begin
    hm <= {i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw};
    vm <= {i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw};
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_hs  <= i_hsync;
      r_vs  <= i_vsync;
      r_rgb <= {i_red, i_grn, i_blu};
    end
  end

  mword_t hcur;
  mword_t vcur;
  logic   h_rise;
  logic   h_wrap;
  logic   h_viol;
  logic   v_rise;
  logic   v_wrap;
  logic   v_viol;

  llvga_rx_axis u_h (
    .i_pixclk     (i_pixclk),
    .i_reset_n    (i_reset_n),
    .i_porch      (hm.porch),
    .i_synch      (hm.synch),
    .i_raw        (hm.raw),
    .i_adv        (1'b1),
    .i_smp        (1'b1),
    .i_sync       (r_hs),
    .o_pos        (hcur),
    .o_rise       (h_rise),
    .o_wrap       (h_wrap),
    .o_viol       (h_viol)
`ifdef LLVGA_RX_MEASURE_EN
    ,
    .o_meas_raw   (o_meas_hraw),
    .o_meas_pulse (o_meas_hsync)
`endif
  );

  // vertical axis: counts at line wraps, samples vsync at hsync rises
  llvga_rx_axis u_v (
    .i_pixclk     (i_pixclk),
    .i_reset_n    (i_reset_n),
    .i_porch      (vm.porch),
    .i_synch      (vm.synch),
    .i_raw        (vm.raw),
    .i_adv        (h_wrap),
    .i_smp        (h_rise),
    .i_sync       (r_vs),
    .o_pos        (vcur),
    .o_rise       (v_rise),
    .o_wrap       (v_wrap),
    .o_viol       (v_viol)
`ifdef LLVGA_RX_MEASURE_EN
    ,
    .o_meas_raw   (o_meas_vraw),
    .o_meas_pulse (o_meas_vsync)
`endif
  );

  logic viol;
  logic lock_go;
  logic pix_ok;
  logic act;

  assign viol = (h_viol && state != SEARCH)
              || (v_viol && (state == HLOCK || state == LOCKED));
  assign lock_go = (state == HLOCK) && !viol && v_wrap
                && (cnt + 4'd1 == LF);
  // next state is LOCKED: lets the first pixel of the frame through
  assign pix_ok = lock_go || (state == LOCKED && !viol);
  assign act = pix_ok && (hcur < hm.width) && (vcur < vm.width);

  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      state    <= SEARCH;
      cnt      <= '0;
      o_valid  <= 1'b0;
      o_pixel  <= '0;
      o_hlast  <= 1'b0;
      o_vlast  <= 1'b0;
      o_locked <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_err    <= viol;
      o_locked <= pix_ok;
      o_valid  <= act;
      o_pixel  <= act ? r_rgb : '0;
      o_hlast  <= act && (hcur == hm.width - 1'b1);
      o_vlast  <= act && (vcur == vm.width - 1'b1);
      unique case (state)
        SEARCH: begin
          if (h_rise)
            state <= HSYNC_WAIT;
        end
        HSYNC_WAIT: begin
          if (viol) begin
            state <= SEARCH;
          end else if (v_rise) begin
            state <= HLOCK;
            cnt   <= '0;
          end
        end
        HLOCK: begin
          if (viol) begin
            state <= SEARCH;
            cnt   <= '0;
          end else if (v_wrap) begin
            cnt <= cnt + 4'd1;
            if (lock_go)
              state <= LOCKED;
          end
        end
        LOCKED: begin
          if (viol) begin
            state <= SEARCH;
            cnt   <= '0;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_llvga_rx.sv
// tb_llvga_rx: directed VGA stream with scoreboard checking of llvga_rx.
// Mode h 20/22/25/30, v 18/19/21/24; define LLVGA_RX_MEASURE_EN for o_meas_*.
module tb_llvga_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] hw, hp, hs_e, hr, vh, vp, vs_e, vr;
  logic        hs, vs;
  logic [3:0]  red, grn, blu;
  logic        o_valid, o_hlast, o_vlast, o_locked, o_err;
  logic [11:0] o_pixel;
`ifdef LLVGA_RX_MEASURE_EN
  logic [11:0] m_hraw, m_hsync, m_vraw, m_vsync;
`endif

  always #5 clk = ~clk;

  llvga_rx dut (
    .i_pixclk    (clk),
    .i_reset_n   (rst_n),
    .i_hm_width  (hw),
    .i_hm_porch  (hp),
    .i_hm_synch  (hs_e),
    .i_hm_raw    (hr),
    .i_vm_height (vh),
    .i_vm_porch  (vp),
    .i_vm_synch  (vs_e),
    .i_vm_raw    (vr),
    .i_hsync     (hs),
    .i_vsync     (vs),
    .i_red       (red),
    .i_grn       (grn),
    .i_blu       (blu),
    .o_valid     (o_valid),
    .o_pixel     (o_pixel),
    .o_hlast     (o_hlast),
    .o_vlast     (o_vlast),
    .o_locked    (o_locked),
    .o_err       (o_err)
`ifdef LLVGA_RX_MEASURE_EN
    ,
    .o_meas_hraw (m_hraw),
    .o_meas_hsync(m_hsync),
    .o_meas_vraw (m_vraw),
    .o_meas_vsync(m_vsync)
`endif
  );

  typedef struct {
    int          cyc;
    logic [11:0] pix;
    logic        hl;
    logic        vl;
  } exp_t;

  exp_t pq[$];
  int   eq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pix_ctr = 1;
  bit   mon_en = 1'b1;
  bit   err_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (err_d)
        chk("locked_after_err", int'(o_locked), 0);
      err_d <= o_err;
      if (o_err) begin
        if (eq.size() == 0) begin
          chk("err_unexpected", int'(o_err), 0);
        end else begin
          chk("err_cycle", cyc, eq[0]);
          void'(eq.pop_front());
        end
      end
      if (o_valid) begin
        if (pq.size() == 0) begin
          chk("valid_unexpected", int'(o_valid), 0);
        end else begin
          chk("pix_cycle", cyc, pq[0].cyc);
          chk("pixel", int'(o_pixel), int'(pq[0].pix));
          chk("hlast", int'(o_hlast), int'(pq[0].hl));
          chk("vlast", int'(o_vlast), int'(pq[0].vl));
          void'(pq.pop_front());
        end
      end else begin
        chk("idle_zero", int'({o_pixel, o_hlast, o_vlast}), 0);
      end
    end
  end

  // one frame of the transmitter; pushes the pixels/errors it implies
  task automatic run_frame(
    input int lines, input bit val, input int cut_v, input int cut_h,
    input bit no_vs, input int str_v, input int err_v, input int err_h,
    input int rst_v, input int rst_h, input int lk);
    logic [11:0] pix;
    exp_t        e;
    for (int v = 0; v < lines; v++) begin
      for (int h = 0; h < 30; h++) begin
        @(negedge clk);
        if (v == rst_v && h == rst_h + 1)
          chk("reset_zero", int'({o_valid, o_pixel, o_hlast,
                                  o_vlast, o_locked, o_err}), 0);
        if (v == 10 && h == 0 && lk >= 0)
          chk("locked", int'(o_locked), lk);
        pix = pix_ctr[11:0];
        pix_ctr++;
        rst_n = !(v == rst_v && h == rst_h);
        hs = (h >= 22 && h < 25) || (v == str_v && h == 25);
        vs = !no_vs && v >= 19 && v < 21;
        {red, grn, blu} = pix;
        if (val && h < 20 && v < 18 &&
            (cut_v < 0 || v < cut_v || (v == cut_v && h < cut_h))) begin
          e.cyc = cyc + 2;
          e.pix = pix;
          e.hl  = (h == 19);
          e.vl  = (v == 17);
          pq.push_back(e);
        end
        if (v == err_v && h == err_h)
          eq.push_back(cyc + 2);
      end
    end
  endtask

  initial begin
    hw = 12'd20; hp = 12'd22; hs_e = 12'd25; hr = 12'd30;
    vh = 12'd18; vp = 12'd19; vs_e = 12'd21; vr = 12'd24;
    rst_n = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    {red, grn, blu} = 12'h0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'({o_valid, o_pixel, o_hlast,
                             o_vlast, o_locked, o_err}), 0);
    // frames 0,1 align and count; frame 2 is locked
    run_frame(24, 0, -1, 0, 0, -1, -1, 0, -1, 0, 0);
    run_frame(24, 0, -1, 0, 0, -1, -1, 0, -1, 0, 0);
    run_frame(24, 1, -1, 0, 0, -1, -1, 0, -1, 0, 1);
`ifdef LLVGA_RX_MEASURE_EN
    chk("meas_hraw", int'(m_hraw), 30);
    chk("meas_hsync", int'(m_hsync), 3);
    chk("meas_vraw", int'(m_vraw), 24);
    chk("meas_vsync", int'(m_vsync), 2);
`endif
    // stretched hsync on line 5, relock after frames 3,4
    run_frame(24, 1, 5, 20, 0, 5, 5, 26, -1, 0, 0);
    run_frame(24, 0, -1, 0, 0, -1, -1, 0, -1, 0, 0);
    run_frame(24, 1, -1, 0, 0, -1, -1, 0, -1, 0, 1);
    // frame 6 without vsync, error at the frame wrap
    run_frame(24, 1, -1, 0, 1, -1, -1, 0, -1, 0, 1);
    run_frame(24, 0, -1, 0, 0, -1, 0, 0, -1, 0, 0);
    run_frame(24, 0, -1, 0, 0, -1, -1, 0, -1, 0, 0);
    // one-cycle reset mid-line
    run_frame(24, 1, 3, 9, 0, -1, -1, 0, 3, 10, 0);
    run_frame(24, 0, -1, 0, 0, -1, -1, 0, -1, 0, 0);
    run_frame(24, 1, -1, 0, 0, -1, -1, 0, -1, 0, 1);
    run_frame(1, 1, -1, 0, 0, -1, -1, 0, -1, 0, -1);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    chk("pix_queue_empty", pq.size(), 0);
    chk("err_queue_empty", eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
